// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   Sequential instruction fetcher with a single output register and a
//   valid/ready handshake toward decode. It reads a combinational
//   instruction memory at the current PC. Redirects flush the output
//   register and move the PC. A fetched HALT_WORD stops further fetches
//   until the next redirect or reset.
//
// Ports
//   clk              rising-edge clock
//   rst              asynchronous active-high reset
//   run              fetch enable (0 suppresses new loads only)
//   imem_addr        word address to instruction memory, {zeros, pc}
//   imem_instr       instruction word at imem_addr, same cycle
//   redirect_valid   1-cycle branch/jump request
//   redirect_target  new PC word address, low ADDR_W bits used
//   out_valid        out_instr/out_pc hold a fetched instruction
//   out_ready        decode accepts the output this cycle
//   out_instr        fetched instruction
//   out_pc           word address of out_instr, zero-extended
//   halted           registered, high while in HALTED
//   fetch_count      saturating count of loads into the output register
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_RUN    | fetching whenever run=1 and the output slot is free
// ST_HALTED | halt word fetched; no loads until redirect or reset

module instruction_fetch_unit #(
    parameter int          ADDR_W    = 10,
    parameter int          RESET_PC  = 0,
    parameter logic [31:0] HALT_WORD = 32'hFC000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        halted,
    output logic [31:0] fetch_count
);

    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } state_t;

    localparam logic [ADDR_W-1:0] RESET_PC_W = ADDR_W'(RESET_PC);

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic              slot_free;
    logic              load;
    logic              unused_target_hi;

    // Only the low ADDR_W bits of the target address the memory.
    assign unused_target_hi = ^redirect_target[31:ADDR_W];

    assign imem_addr = {{(32-ADDR_W){1'b0}}, pc};
    assign slot_free = !out_valid || out_ready;
    assign load      = (state == ST_RUN) && run && slot_free && !redirect_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_RUN;
            pc          <= RESET_PC_W;
            out_valid   <= 1'b0;
            out_instr   <= 32'd0;
            out_pc      <= 32'd0;
            fetch_count <= 32'd0;
            halted      <= 1'b0;
        end else if (redirect_valid) begin
            // Redirect wins over load, stall and halt detection; flush even
            // if decode is stalled.
            pc        <= redirect_target[ADDR_W-1:0];
            out_valid <= 1'b0;
            state     <= ST_RUN;
            halted    <= 1'b0;
        end else if (load) begin
            out_instr <= imem_instr;
            out_pc    <= {{(32-ADDR_W){1'b0}}, pc};
            out_valid <= 1'b1;
            pc        <= pc + 1'b1;
            if (fetch_count != 32'hFFFF_FFFF)
                fetch_count <= fetch_count + 32'd1;
            // The halt word itself is still delivered downstream.
            if (imem_instr == HALT_WORD) begin
                state  <= ST_HALTED;
                halted <= 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
